// File: rtl/rst_seq_pkg.sv
// Shared types and default sizing for the reset sequencer.
package rst_seq_pkg;

    // Sequencer states: hold all, walk stages, all up, retries exhausted.
    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2,
        ST_FAIL   = 2'd3
    } seq_state_t;

    localparam int DEF_N_STAGE   = 4;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_HOLD      = 16;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int DEF_MAX_RETRY = 3;

endpackage

// File: rtl/rst_seq_cnt.sv
// Shared hold/timeout counter: clear beats enable, terminal compare is a
// runtime value so one counter serves both the hold and the per-stage wait.
module rst_seq_cnt
    import rst_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    // Count up while enabled; any clear returns to zero.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign hit = (cnt == term);

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-stage resets one at a time in index order, waiting for each
// stage's ready before releasing the next. Re-runs on lock loss or soft reset.
// Build option: RST_SEQ_TIMEOUT_EN adds the per-stage watchdog, retry counter
// and sticky FAIL state; without it WAIT waits forever and the fail/retry
// outputs are tied low.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGE        = DEF_N_STAGE,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int HOLD_CYCLES    = DEF_HOLD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic                           clk,
    input  logic                           fpga_reset_i,
    input  logic                           soft_reset_i,
    input  logic [N_STAGE-1:0]             stage_ready_i,
    output logic [N_STAGE-1:0]             stage_reset_o,
    output logic                           seq_done_o,
    output logic                           seq_fail_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

    localparam int               IW        = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam logic [IW-1:0]    LAST_IDX  = IW'(N_STAGE - 1);
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int               RW        = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [CNT_W-1:0] TMO_TERM  = CNT_W'(TIMEOUT_CYCLES - 1);
`else
    localparam int               unused_tmo = TIMEOUT_CYCLES;
`endif

    seq_state_t       state;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_hit, cnt_clr, cnt_en;
    logic             ready_cur, hold_done, stage_ok, tmo, lock_lost;

    // Decode the events that move the FSM; any of them restarts the counter.
    always_comb begin
        ready_cur = stage_ready_i[idx];
        hold_done = (state == ST_ASSERT) && cnt_hit;
        stage_ok  = (state == ST_WAIT) && ready_cur;
        lock_lost = (state == ST_DONE) && !(&stage_ready_i);
`ifdef RST_SEQ_TIMEOUT_EN
        tmo       = (state == ST_WAIT) && !ready_cur && cnt_hit;
        cnt_term  = (state == ST_ASSERT) ? HOLD_TERM : TMO_TERM;
        cnt_en    = (state == ST_ASSERT) || (state == ST_WAIT);
`else
        // No watchdog: let the WAIT count saturate at all-ones so it never wraps.
        tmo       = 1'b0;
        cnt_term  = (state == ST_ASSERT) ? HOLD_TERM : '1;
        cnt_en    = (state == ST_ASSERT) || ((state == ST_WAIT) && !cnt_hit);
`endif
        cnt_clr   = soft_reset_i | hold_done | stage_ok | tmo | lock_lost;
    end

    rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (fpga_reset_i),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .term (cnt_term),
        .cnt  (cnt),
        .hit  (cnt_hit)
    );

    // Sequencer FSM with registered reset vector, done/fail flags and retries.
    always_ff @(posedge clk) begin
        if (fpga_reset_i || soft_reset_i) begin
            state         <= ST_ASSERT;
            idx           <= '0;
            stage_reset_o <= '1;
            seq_done_o    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            seq_fail_o    <= 1'b0;
            retry_cnt_o   <= '0;
`endif
        end else begin
            case (state)
                ST_ASSERT: begin
                    stage_reset_o <= '1;
                    if (hold_done) begin
                        state         <= ST_WAIT;
                        idx           <= '0;
                        stage_reset_o <= ~N_STAGE'(1);
                    end
                end
                ST_WAIT: begin
                    if (ready_cur) begin
                        if (idx == LAST_IDX) begin
                            state      <= ST_DONE;
                            seq_done_o <= 1'b1;
                        end else begin
                            idx           <= idx + 1'b1;
                            stage_reset_o <= stage_reset_o & ~(N_STAGE'(2) << idx);
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (tmo) begin
                        stage_reset_o <= '1;
                        idx           <= '0;
                        if (retry_cnt_o < RETRY_MAX) begin
                            retry_cnt_o <= retry_cnt_o + 1'b1;
                            state       <= ST_ASSERT;
                        end else begin
                            state      <= ST_FAIL;
                            seq_fail_o <= 1'b1;
                        end
                    end
`endif
                end
                ST_DONE: begin
                    if (lock_lost) begin
                        state         <= ST_ASSERT;
                        idx           <= '0;
                        stage_reset_o <= '1;
                        seq_done_o    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
                        retry_cnt_o   <= '0;
`endif
                    end
                end
                default: begin
                    // FAIL: park with everything held until a reset request.
                    stage_reset_o <= '1;
`ifdef RST_SEQ_TIMEOUT_EN
                    seq_fail_o    <= 1'b1;
`endif
                end
            endcase
        end
    end

`ifndef RST_SEQ_TIMEOUT_EN
    assign seq_fail_o  = 1'b0;
    assign retry_cnt_o = '0;
`endif

endmodule
